// File: rtl/nic8_ctrl_pkg.sv
// Shared encodings and default widths for the nic8 run/halt sequencer.
package nic8_ctrl_pkg;

  localparam int NIC8_AW = 8;
  localparam int NIC8_SW = 8;
  localparam int NIC8_CW = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } run_state_e;

endpackage

// File: rtl/bp_match.sv
// Address comparator for a breakpoint (or watchpoint); skip masks one match.
module bp_match #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] bp_addr,
  input  logic          bp_en,
  input  logic          skip,
  output logic          bp_fire
);

  assign bp_fire = bp_en && (addr == bp_addr) && !skip;

endmodule

// File: rtl/run_control.sv
// Run/halt/single-step sequencer producing the nic8 datapath clock enable.
module run_control
  import nic8_ctrl_pkg::*;
#(
  parameter int AW = NIC8_AW,
  parameter int SW = NIC8_SW,
  parameter int CW = NIC8_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run_cmd,
  input  logic          halt_cmd,
  input  logic          step_cmd,
  input  logic [SW-1:0] step_n,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic          clr_count,
  input  logic [AW-1:0] pc,
  output logic          cpu_en,
  output logic [1:0]    state,
  output logic          halted,
  output logic          bp_hit,
  output logic [CW-1:0] cycles
);

  run_state_e    state_q, state_d;
  logic [SW-1:0] step_rem_q, step_rem_d;
  logic          skip_q, skip_d;
  logic          bp_hit_q, bp_hit_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          bp_fire;
  logic [SW-1:0] step_load;

  bp_match #(.AW(AW)) u_bp_match (
    .addr    (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .skip    (skip_q),
    .bp_fire (bp_fire)
  );

  assign cpu_en    = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_fire;
  assign step_load = (step_n == '0) ? SW'(1) : step_n;

  always_comb begin
    state_d    = state_q;
    step_rem_d = step_rem_q;
    skip_d     = skip_q;
    bp_hit_d   = bp_hit_q;
    cycles_d   = cycles_q;

    // skip only shields the first executed instruction after a resume
    if (cpu_en) begin
      skip_d   = 1'b0;
      cycles_d = cycles_q + CW'(1);
    end
    if (clr_count) cycles_d = '0;

    unique case (state_q)
      ST_HALT, ST_BRK: begin
        if (halt_cmd) begin
          state_d = ST_HALT;
        end else if (step_cmd) begin
          state_d    = ST_STEP;
          step_rem_d = step_load;
          skip_d     = 1'b1;
          bp_hit_d   = 1'b0;
        end else if (run_cmd) begin
          state_d  = ST_RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (halt_cmd) begin
          state_d = ST_HALT;
        end else if (bp_fire) begin
          state_d  = ST_BRK;
          bp_hit_d = 1'b1;
        end else if (step_cmd) begin
          state_d    = ST_STEP;
          step_rem_d = step_load;
        end
      end
      ST_STEP: begin
        if (halt_cmd) begin
          state_d    = ST_HALT;
          step_rem_d = '0;
        end else if (bp_fire) begin
          state_d  = ST_BRK;
          bp_hit_d = 1'b1;
        end else if (step_cmd) begin
          step_rem_d = step_load;
        end else if (run_cmd) begin
          state_d = ST_RUN;
        end else if (cpu_en) begin
          step_rem_d = step_rem_q - SW'(1);
          if (step_rem_q == SW'(1)) state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_HALT;
      step_rem_q <= '0;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      step_rem_q <= step_rem_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
      cycles_q   <= cycles_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT) || (state_q == ST_BRK);
  assign bp_hit = bp_hit_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_run_control.sv
// Directed checks of run_control: per-cycle vector table plus multi-cycle sequences.
module tb_run_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run_cmd, halt_cmd, step_cmd, bp_en, clr_count;
  logic [7:0]  step_n, bp_addr, pc;
  logic        cpu_en, halted, bp_hit;
  logic [1:0]  state;
  logic [15:0] cycles;

  logic        pc_auto;
  logic [7:0]  pc_tab, pc_model;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign pc = pc_auto ? pc_model : pc_tab;

  // stand-in datapath: PC advances only on enabled cycles
  always @(posedge clk) begin
    if (pc_auto && cpu_en) pc_model <= pc_model + 8'd1;
  end

  run_control dut (
    .clk(clk), .reset_n(reset_n), .run_cmd(run_cmd), .halt_cmd(halt_cmd),
    .step_cmd(step_cmd), .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr),
    .clr_count(clr_count), .pc(pc), .cpu_en(cpu_en), .state(state),
    .halted(halted), .bp_hit(bp_hit), .cycles(cycles)
  );

  typedef struct {
    logic        run, halt, step;
    logic [7:0]  n;
    logic        be;
    logic [7:0]  ba;
    logic        clr;
    logic [7:0]  pcv;
    logic [1:0]  e_state;
    logic        e_en, e_halted, e_bphit;
    logic [15:0] e_cycles;
  } vec_t;

  vec_t vt[35];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run_cmd = 0; halt_cmd = 0; step_cmd = 0; clr_count = 0;
  endtask

  task automatic pulse_run();
    run_cmd = 1; tick(); run_cmd = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; tick(); reset_n = 1;
  endtask

  function automatic vec_t mk(input logic r, h, s, input logic [7:0] n, input logic be,
                              input logic [7:0] ba, input logic clr, input logic [7:0] pcv,
                              input logic [1:0] es, input logic een, eh, ebp,
                              input logic [15:0] ec);
    vec_t v;
    v.run = r; v.halt = h; v.step = s; v.n = n; v.be = be; v.ba = ba; v.clr = clr;
    v.pcv = pcv; v.e_state = es; v.e_en = een; v.e_halted = eh; v.e_bphit = ebp;
    v.e_cycles = ec;
    return v;
  endfunction

  initial begin
    // fields: run halt step n be ba clr pc | state en halted bp_hit cycles
    vt[0]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd0);
    vt[1]  = mk(0,0,1,8'd3,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd0);
    vt[2]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd2,1,0,0,16'd0);
    vt[3]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd2,1,0,0,16'd1);
    vt[4]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd2,1,0,0,16'd2);
    vt[5]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd3);
    vt[6]  = mk(0,0,1,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd3);
    vt[7]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd2,1,0,0,16'd3);
    vt[8]  = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd4);
    vt[9]  = mk(1,0,1,8'd3,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd4);
    vt[10] = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd2,1,0,0,16'd4);
    vt[11] = mk(1,0,0,8'd0,0,8'd0,0,8'd0, 2'd2,1,0,0,16'd5);
    vt[12] = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd1,1,0,0,16'd6);
    vt[13] = mk(1,1,1,8'd2,0,8'd0,0,8'd0, 2'd1,1,0,0,16'd7);
    vt[14] = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd8);
    vt[15] = mk(1,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd8);
    vt[16] = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd1,1,0,0,16'd8);
    vt[17] = mk(0,1,0,8'd0,0,8'd0,0,8'd0, 2'd1,1,0,0,16'd9);
    vt[18] = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd10);
    vt[19] = mk(0,0,0,8'd0,0,8'd0,1,8'd0, 2'd0,0,1,0,16'd10);
    vt[20] = mk(0,0,0,8'd0,0,8'd0,0,8'd0, 2'd0,0,1,0,16'd0);
    vt[21] = mk(0,0,0,8'd0,1,8'd7,0,8'd7, 2'd0,0,1,0,16'd0);
    vt[22] = mk(1,0,0,8'd0,1,8'd7,0,8'd7, 2'd0,0,1,0,16'd0);
    vt[23] = mk(0,0,0,8'd0,1,8'd7,0,8'd7, 2'd1,1,0,0,16'd0);
    vt[24] = mk(0,0,0,8'd0,1,8'd7,0,8'd7, 2'd1,0,0,0,16'd1);
    vt[25] = mk(0,0,0,8'd0,1,8'd7,0,8'd7, 2'd3,0,1,1,16'd1);
    vt[26] = mk(0,1,0,8'd0,0,8'd7,0,8'd7, 2'd3,0,1,1,16'd1);
    vt[27] = mk(0,0,0,8'd0,0,8'd7,0,8'd7, 2'd0,0,1,1,16'd1);
    vt[28] = mk(1,0,0,8'd0,1,8'd7,0,8'd7, 2'd0,0,1,1,16'd1);
    vt[29] = mk(0,0,0,8'd0,1,8'd7,0,8'd7, 2'd1,1,0,0,16'd1);
    vt[30] = mk(0,0,0,8'd0,1,8'd9,0,8'd7, 2'd1,1,0,0,16'd2);
    vt[31] = mk(0,0,0,8'd0,1,8'd7,0,8'd7, 2'd1,0,0,0,16'd3);
    vt[32] = mk(0,0,0,8'd0,0,8'd7,0,8'd7, 2'd3,0,1,1,16'd3);
    vt[33] = mk(0,1,0,8'd0,0,8'd7,0,8'd7, 2'd3,0,1,1,16'd3);
    vt[34] = mk(0,0,0,8'd0,0,8'd7,0,8'd7, 2'd0,0,1,1,16'd3);

    idle_inputs();
    step_n = 0; bp_en = 0; bp_addr = 0; pc_auto = 0; pc_tab = 0; pc_model = 0;
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1;

    for (int i = 0; i < 35; i++) begin
      run_cmd = vt[i].run; halt_cmd = vt[i].halt; step_cmd = vt[i].step;
      step_n = vt[i].n; bp_en = vt[i].be; bp_addr = vt[i].ba;
      clr_count = vt[i].clr; pc_tab = vt[i].pcv;
      @(negedge clk);
      check($sformatf("vec%0d.state", i),  32'(state),  32'(vt[i].e_state));
      check($sformatf("vec%0d.cpu_en", i), 32'(cpu_en), 32'(vt[i].e_en));
      check($sformatf("vec%0d.halted", i), 32'(halted), 32'(vt[i].e_halted));
      check($sformatf("vec%0d.bp_hit", i), 32'(bp_hit), 32'(vt[i].e_bphit));
      check($sformatf("vec%0d.cycles", i), 32'(cycles), 32'(vt[i].e_cycles));
      $display("vec %0d: state=%0d cpu_en=%0b halted=%0b bp_hit=%0b cycles=%0d",
               i, state, cpu_en, halted, bp_hit, cycles);
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // breakpoint with incrementing PC
    do_reset();
    pc_model = 0; pc_auto = 1; bp_en = 1; bp_addr = 8'h05;
    pulse_run();
    for (int n = 0; n < 50 && state != 2'd3; n++) tick();
    check("brk.state", 32'(state), 32'd3);
    check("brk.bp_hit", 32'(bp_hit), 32'd1);
    check("brk.cycles", 32'(cycles), 32'd5);
    check("brk.pc", 32'(pc), 32'h05);
    check("brk.cpu_en", 32'(cpu_en), 32'd0);
    $display("brk: state=%0d pc=%0h cycles=%0d bp_hit=%0b", state, pc, cycles, bp_hit);
    pulse_run();
    @(negedge clk);
    check("resume.state", 32'(state), 32'd1);
    check("resume.bp_hit", 32'(bp_hit), 32'd0);
    check("resume.cpu_en_at_bp", 32'(cpu_en), 32'd1);
    tick();
    check("resume.pc", 32'(pc), 32'h06);
    check("resume.cpu_en_after", 32'(cpu_en), 32'd1);
    $display("resume: state=%0d pc=%0h cycles=%0d", state, pc, cycles);

    // reset mid-RUN
    bp_en = 0;
    repeat (5) tick();
    do_reset();
    check("rst.state", 32'(state), 32'd0);
    check("rst.cpu_en", 32'(cpu_en), 32'd0);
    check("rst.cycles", 32'(cycles), 32'd0);
    check("rst.bp_hit", 32'(bp_hit), 32'd0);
    check("rst.halted", 32'(halted), 32'd1);
    $display("reset mid-run: state=%0d cycles=%0d", state, cycles);

    // counter clear coincident with increment, then wrap
    pulse_run();
    for (int n = 0; n < 100 && cycles != 16'h0010; n++) tick();
    check("cnt.reach16", 32'(cycles), 32'h10);
    clr_count = 1;
    @(negedge clk);
    check("cnt.en_during_clr", 32'(cpu_en), 32'd1);
    tick();
    clr_count = 0;
    check("cnt.clr_wins", 32'(cycles), 32'd0);
    $display("clear: cycles=%0d", cycles);
    for (int n = 0; n < 70000 && cycles != 16'hFFFF; n++) tick();
    check("cnt.reach_ffff", 32'(cycles), 32'hFFFF);
    check("cnt.en_at_ffff", 32'(cpu_en), 32'd1);
    tick();
    check("cnt.wrap", 32'(cycles), 32'h0000);
    $display("wrap: cycles=%0h", cycles);

    // halt latency
    halt_cmd = 1;
    @(negedge clk);
    check("halt.en_sampling", 32'(cpu_en), 32'd1);
    tick();
    halt_cmd = 0;
    check("halt.en_next", 32'(cpu_en), 32'd0);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.cycles", 32'(cycles), 32'd1);
    $display("halt: state=%0d cpu_en=%0b cycles=%0d", state, cpu_en, cycles);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
Run/halt/single-step sequencer for the nic8 datapath. Generates the datapath clock enable (cpu_en) that gates every PC/IR/AR/BR/XR/QR register update. Supports a PC breakpoint, an N-step mode and a count of enabled cycles. Sits between the bench/front-panel command inputs and the CPU core; the core's pc output feeds back for breakpoint comparison.

Parameters:
AW, 8, PC/breakpoint address width
SW, 8, step-count width
CW, 16, enabled-cycle counter width

Ports:
clk  input  1  system clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset
run_cmd  input  1  one-cycle pulse: free-run
halt_cmd  input  1  one-cycle pulse: stop
step_cmd  input  1  one-cycle pulse: execute step_n enabled cycles, then halt
step_n  input  SW  step count, sampled with step_cmd; 0 treated as 1
bp_en  input  1  breakpoint enable
bp_addr  input  AW  breakpoint PC value
clr_count  input  1  one-cycle pulse: clear cycles
pc  input  AW  current PC from datapath
cpu_en  output  1  datapath clock enable (combinational)
state  output  2  HALT=0, RUN=1, STEP=2, BRK=3
halted  output  1  state is HALT or BRK
bp_hit  output  1  sticky breakpoint flag
cycles  output  CW  count of cycles with cpu_en=1

Behaviour:
- Reset (reset_n=0 at posedge): state=HALT, step_rem=0, skip=0, bp_hit=0, cycles=0; therefore cpu_en=0, halted=1. Reset overrides every command, including mid-RUN/STEP.
- bp_fire = bp_en && pc==bp_addr && !skip (combinational).
- cpu_en = (state==RUN || state==STEP) && !bp_fire. An instruction at bp_addr is never executed while the breakpoint is armed.
- Command priority when pulses coincide: halt_cmd > step_cmd > run_cmd. Commands are sampled at posedge and take effect from the next cycle; the cycle in which halt_cmd is sampled still has cpu_en per the current state.
- HALT/BRK: run_cmd -> RUN; step_cmd -> STEP with step_rem = (step_n==0 ? 1 : step_n); halt_cmd -> HALT (from BRK: clears nothing else). Either exit from BRK/HALT into RUN/STEP sets skip=1 and clears bp_hit.
- RUN: halt_cmd -> HALT; else bp_fire -> BRK, bp_hit=1; step_cmd -> STEP (reload step_rem, skip unchanged); run_cmd ignored.
- STEP: halt_cmd -> HALT, step_rem=0; else bp_fire -> BRK, bp_hit=1; else if cpu_en: step_rem-=1, and if step_rem==1 -> HALT. step_cmd while STEP reloads step_rem; run_cmd -> RUN.
- skip clears on the first cycle with cpu_en=1, so one instruction executes from the breakpoint address before re-arming.
- cycles: +1 on each cpu_en=1 cycle, wraps from all-ones to 0 silently. clr_count sets it to 0 and wins over a simultaneous increment.
- bp_en low, or bp_addr changed, takes effect in the same cycle (combinational compare).
- state encoding is fixed as listed; BRK is distinguishable from HALT only by state and bp_hit.

Decomposition:
- Package nic8_ctrl_pkg: state encoding constants (HALT, RUN, STEP, BRK), default widths AW/SW/CW.
- Sub-module bp_match (pc, bp_addr, bp_en, skip -> bp_fire) is natural and reusable for a future data-address watchpoint.
- Everything else stays in one always block plus the cpu_en assign.

Test Plan:
- Reset mid-RUN: run_cmd, 5 cycles, then reset_n=0 for 1 cycle -> state=0, cpu_en=0, cycles=0, bp_hit=0 on the following cycle.
- Step: from HALT, step_cmd with step_n=3 -> cpu_en high exactly 3 cycles, then state=0; cycles=3. step_n=0 -> exactly 1 enabled cycle.
- Breakpoint: bp_en=1, bp_addr=0x05, run_cmd, PC increments from 0 -> cpu_en drops in the cycle pc==0x05, state=3, bp_hit=1, cycles=5. Then run_cmd -> one cycle at 0x05 executes (skip), bp_hit=0, run continues.
- Priority: halt_cmd, step_cmd and run_cmd asserted in the same cycle from RUN -> next state HALT. step_cmd+run_cmd from HALT -> STEP.
- Counter: clr_count coincident with an enabled cycle at cycles=0x0010 -> cycles=0. Preload by running 0xFFFF cycles, then one more -> cycles wraps to 0x0000.
- Halt latency: halt_cmd during RUN -> cpu_en still 1 in the sampling cycle, 0 from the next; halted=1.
